// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the pipeline request/response handshake and the data-memory port of
// the memory-stage initiator (mem_access_unit).
//
// Signals
//   req_valid      pipeline -> unit   request present
//   req_ready      unit -> pipeline   unit idle; accept when valid & ready
//   req_load       pipeline -> unit   request is a load
//   req_store      pipeline -> unit   request is a store
//   req_word       pipeline -> unit   1 = 32-bit access, 0 = byte access
//   req_signed     pipeline -> unit   byte load sign-extends when 1
//   req_addr       pipeline -> unit   byte address
//   req_wdata      pipeline -> unit   store data (byte store uses [7:0])
//   resp_valid     unit -> pipeline   one-cycle completion pulse
//   resp_fault     unit -> pipeline   request rejected, no memory access made
//   resp_data      unit -> pipeline   load result, 0 for stores and faults
//   mem_address    unit -> memory     address
//   mem_write_data unit -> memory     write data
//   mem_memRead    unit -> memory     read strobe
//   mem_memWrite   unit -> memory     write strobe
//   mem_word       unit -> memory     word/byte select
//   mem_read_data  memory -> unit     read data, combinational from address
//
// Modports
//   slave  : view of the unit itself
//   master : view of the surrounding pipeline / memory environment
// ----------------------------------------------------------------------------
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_load;
   logic        req_store;
   logic        req_word;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic        resp_fault;
   logic [31:0] resp_data;

   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_memRead;
   logic        mem_memWrite;
   logic        mem_word;
   logic [31:0] mem_read_data;

   modport slave (
      input  req_valid, req_load, req_store, req_word, req_signed,
             req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_fault, resp_data,
             mem_address, mem_write_data, mem_memRead, mem_memWrite, mem_word
   );

   modport master (
      output req_valid, req_load, req_store, req_word, req_signed,
             req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_fault, resp_data,
             mem_address, mem_write_data, mem_memRead, mem_memWrite, mem_word
   );

endinterface : mem_access_unit_if

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage initiator between the pipeline and a byte-addressed data
// memory. Accepts one load/store at a time, range-checks it, drives the memory
// port for MEM_LATENCY cycles, extends load data and returns a one-cycle
// completion or fault response. req_ready low doubles as the pipeline stall.
//
// Parameters
//   MEM_BYTES    data memory size in bytes (highest legal address MEM_BYTES-1)
//   MEM_LATENCY  cycles memRead/memWrite stay asserted per access (>= 1)
//
// Ports
//   clk    in  clock, all state on the rising edge
//   reset  in  synchronous active-high reset
//   bus    slave modport of mem_access_unit_if (request, response, memory)
//
// Build option
//   MEM_ACCESS_ALIGN_CHECK_EN  when defined, word accesses with addr[1:0] != 0
//                              are rejected with a fault; when undefined they
//                              are issued as-is to the byte-addressed memory.
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned MEM_BYTES   = 22,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   mem_access_unit_if.slave  bus
);

   localparam int unsigned        CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MEM_LATENCY - 1);
   localparam logic [32:0]        BYTES_X  = 33'(MEM_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               signed_q, signed_d;
   logic               req_ready_q, req_ready_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_fault_q, resp_fault_d;
   logic [31:0]        resp_data_q, resp_data_d;
   logic [31:0]        mem_address_q, mem_address_d;
   logic [31:0]        mem_write_data_q, mem_write_data_d;
   logic               mem_read_q, mem_read_d;
   logic               mem_write_q, mem_write_d;
   logic               mem_word_q, mem_word_d;

   logic               accept_c;
   logic               kind_bad_c;
   logic               range_bad_c;
   logic               align_bad_c;
   logic               illegal_c;
   logic [32:0]        addr_ext_c;
   logic [31:0]        load_data_c;

   // Request legality, evaluated on the accept edge from the live req_* inputs
   always_comb begin
      addr_ext_c  = {1'b0, bus.req_addr};
      kind_bad_c  = (bus.req_load == bus.req_store);
      // Word access needs all four bytes addr..addr+3 inside the memory
      if (bus.req_word) begin
         range_bad_c = ((addr_ext_c + 33'd3) >= BYTES_X);
      end else begin
         range_bad_c = (addr_ext_c >= BYTES_X);
      end
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      align_bad_c = bus.req_word & (|bus.req_addr[1:0]);
`else
      align_bad_c = 1'b0;
`endif
      illegal_c   = kind_bad_c | range_bad_c | align_bad_c;
   end

   // Load-data extension; byte loads ignore the upper memory bits
   always_comb begin
      if (mem_word_q) begin
         load_data_c = bus.mem_read_data;
      end else begin
         load_data_c = {{24{signed_q & bus.mem_read_data[7]}}, bus.mem_read_data[7:0]};
      end
   end

   assign accept_c = (state_q == ST_IDLE) & bus.req_valid;

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         signed_q         <= 1'b0;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         resp_fault_q     <= 1'b0;
         resp_data_q      <= '0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_word_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         signed_q         <= signed_d;
         req_ready_q      <= req_ready_d;
         resp_valid_q     <= resp_valid_d;
         resp_fault_q     <= resp_fault_d;
         resp_data_q      <= resp_data_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
         mem_word_q       <= mem_word_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      signed_d         = signed_q;
      resp_valid_d     = 1'b0;
      resp_fault_d     = 1'b0;
      resp_data_d      = '0;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;
      mem_read_d       = mem_read_q;
      mem_write_d      = mem_write_q;
      mem_word_d       = mem_word_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (illegal_c) begin
                  // Rejected: answer straight away, memory port untouched
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
               end else begin
                  state_d          = ST_ACCESS;
                  cnt_d            = '0;
                  signed_d         = bus.req_signed;
                  mem_address_d    = bus.req_addr;
                  mem_write_data_d = bus.req_wdata;
                  mem_word_d       = bus.req_word;
                  mem_read_d       = bus.req_load;
                  mem_write_d      = bus.req_store;
               end
            end
         end

         ST_ACCESS: begin
            if (cnt_q == CNT_LAST) begin
               // Last access cycle: capture read data, drop strobes for RESP
               state_d      = ST_RESP;
               mem_read_d   = 1'b0;
               mem_write_d  = 1'b0;
               resp_valid_d = 1'b1;
               resp_data_d  = mem_read_q ? load_data_c : 32'd0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   assign bus.req_ready      = req_ready_q;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_fault     = resp_fault_q;
   assign bus.resp_data      = resp_data_q;
   assign bus.mem_address    = mem_address_q;
   assign bus.mem_write_data = mem_write_data_q;
   assign bus.mem_memRead    = mem_read_q;
   assign bus.mem_memWrite   = mem_write_q;
   assign bus.mem_word       = mem_word_q;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit. Two instances share the request fields:
// u_dut1 with MEM_LATENCY=1 and u_dut3 with MEM_LATENCY=3, each backed by its
// own 22-byte little-endian memory model. Expected responses are queued when a
// request is driven and popped when resp_valid is seen.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int unsigned NBYTES = 22;

   typedef struct {
      logic        fault;
      logic [31:0] data;
      int          lat;
      int          rd_cyc;
      int          wr_cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset1, reset3;
   logic        valid1, valid3;
   logic        sel;
   logic        mem_clr;
   logic        t_load, t_store, t_word, t_signed;
   logic [31:0] t_addr, t_wdata;

   int vectors    = 0;
   int miscompares = 0;
   exp_t sb[$];

   mem_access_unit_if bus1 ();
   mem_access_unit_if bus3 ();

   mem_access_unit #(.MEM_BYTES(NBYTES), .MEM_LATENCY(1)) u_dut1 (
      .clk   (clk),
      .reset (reset1),
      .bus   (bus1.slave)
   );

   mem_access_unit #(.MEM_BYTES(NBYTES), .MEM_LATENCY(3)) u_dut3 (
      .clk   (clk),
      .reset (reset3),
      .bus   (bus3.slave)
   );

   assign bus1.req_valid  = valid1;
   assign bus1.req_load   = t_load;
   assign bus1.req_store  = t_store;
   assign bus1.req_word   = t_word;
   assign bus1.req_signed = t_signed;
   assign bus1.req_addr   = t_addr;
   assign bus1.req_wdata  = t_wdata;

   assign bus3.req_valid  = valid3;
   assign bus3.req_load   = t_load;
   assign bus3.req_store  = t_store;
   assign bus3.req_word   = t_word;
   assign bus3.req_signed = t_signed;
   assign bus3.req_addr   = t_addr;
   assign bus3.req_wdata  = t_wdata;

   // Memory models
   logic [NBYTES-1:0][7:0] m1, m3;

   function automatic logic [31:0] rd_word(input logic [NBYTES-1:0][7:0] m, input logic [31:0] a);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         if (a < (32'(NBYTES) - 32'(i))) r[8*i +: 8] = m[5'(a) + 5'(i)];
      end
      return r;
   endfunction

   assign bus1.mem_read_data = rd_word(m1, bus1.mem_address);
   assign bus3.mem_read_data = rd_word(m3, bus3.mem_address);

   always @(posedge clk) begin
      if (mem_clr) begin
         m1 <= '0;
      end else if (bus1.mem_memWrite) begin
         for (int i = 0; i < 4; i++) begin
            if ((i == 0 || bus1.mem_word) && bus1.mem_address < (32'(NBYTES) - 32'(i)))
               m1[5'(bus1.mem_address) + 5'(i)] <= bus1.mem_write_data[8*i +: 8];
         end
      end
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         m3 <= '0;
      end else if (bus3.mem_memWrite) begin
         for (int i = 0; i < 4; i++) begin
            if ((i == 0 || bus3.mem_word) && bus3.mem_address < (32'(NBYTES) - 32'(i)))
               m3[5'(bus3.mem_address) + 5'(i)] <= bus3.mem_write_data[8*i +: 8];
         end
      end
   end

   // Observed outputs of the selected instance
   logic        o_ready, o_rvalid, o_fault, o_rd, o_wr, o_word;
   logic [31:0] o_data, o_addr, o_wdata;
   assign o_ready  = sel ? bus3.req_ready      : bus1.req_ready;
   assign o_rvalid = sel ? bus3.resp_valid     : bus1.resp_valid;
   assign o_fault  = sel ? bus3.resp_fault     : bus1.resp_fault;
   assign o_data   = sel ? bus3.resp_data      : bus1.resp_data;
   assign o_addr   = sel ? bus3.mem_address    : bus1.mem_address;
   assign o_wdata  = sel ? bus3.mem_write_data : bus1.mem_write_data;
   assign o_rd     = sel ? bus3.mem_memRead    : bus1.mem_memRead;
   assign o_wr     = sel ? bus3.mem_memWrite   : bus1.mem_memWrite;
   assign o_word   = sel ? bus3.mem_word       : bus1.mem_word;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"},  32'(o_ready),  32'd1);
      check({tag, "_rvalid"}, 32'(o_rvalid), 32'd0);
      check({tag, "_fault"},  32'(o_fault),  32'd0);
      check({tag, "_data"},   o_data,        32'd0);
      check({tag, "_addr"},   o_addr,        32'd0);
      check({tag, "_wdata"},  o_wdata,       32'd0);
      check({tag, "_rd"},     32'(o_rd),     32'd0);
      check({tag, "_wr"},     32'(o_wr),     32'd0);
      check({tag, "_word"},   32'(o_word),   32'd0);
   endtask

   // Drive one request on the selected instance and check its whole transaction
   task automatic run_req(input string tag, input bit s,
                          input bit ld, input bit st, input bit wd, input bit sg,
                          input logic [31:0] a, input logic [31:0] wdat,
                          input bit xf, input logic [31:0] xd);
      exp_t e, got;
      int   lat, cycles, rd_n, wr_n, n;
      bit   port_ok;
      lat = s ? 3 : 1;
      sel = s;
      n   = 0;
      while (!o_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_ready_wait"}, 32'(o_ready), 32'd1);

      t_load = ld; t_store = st; t_word = wd; t_signed = sg;
      t_addr = a;  t_wdata = wdat;
      if (s) valid3 = 1'b1; else valid1 = 1'b1;
      e.fault  = xf;
      e.data   = xf ? 32'd0 : xd;
      e.lat    = xf ? 1 : lat + 1;
      e.rd_cyc = (!xf && ld) ? lat : 0;
      e.wr_cyc = (!xf && st) ? lat : 0;
      sb.push_back(e);

      @(posedge clk); #1;
      valid1 = 1'b0; valid3 = 1'b0;
      t_addr = 32'hFFFF_FFFF; t_wdata = 32'h0; t_word = ~wd; t_signed = ~sg;
      cycles  = 1;
      rd_n    = 0;
      wr_n    = 0;
      port_ok = 1'b1;
      while (!o_rvalid && cycles < 20) begin
         if (o_rd) rd_n++;
         if (o_wr) wr_n++;
         if ((o_rd || o_wr) && (o_addr !== a || o_word !== wd)) port_ok = 1'b0;
         @(posedge clk); #1;
         cycles++;
      end
      if (!o_rvalid) begin
         check({tag, "_resp_timeout"}, 32'(o_rvalid), 32'd1);
         void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         check({tag, "_fault"},   32'(o_fault),      32'(got.fault));
         check({tag, "_data"},    o_data,            got.data);
         check({tag, "_latency"}, 32'(cycles),       32'(got.lat));
         check({tag, "_rd_cyc"},  32'(rd_n),         32'(got.rd_cyc));
         check({tag, "_wr_cyc"},  32'(wr_n),         32'(got.wr_cyc));
         check({tag, "_port"},    32'(port_ok),      32'd1);
         check({tag, "_strb_resp"}, {30'd0, o_rd, o_wr}, 32'd0);
         check({tag, "_rdy_resp"},  32'(o_ready),    32'd0);
         @(posedge clk); #1;
         check({tag, "_pulse"},   32'(o_rvalid),     32'd0);
      end
   endtask

   initial begin
      bit quiet;
      sel = 1'b0;
      valid1 = 1'b0; valid3 = 1'b0;
      reset1 = 1'b1; reset3 = 1'b1;
      mem_clr = 1'b1;
      t_load = 1'b0; t_store = 1'b0; t_word = 1'b0; t_signed = 1'b0;
      t_addr = '0;   t_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      sel = 1'b0; #1; check_reset("rst1");
      sel = 1'b1; #1; check_reset("rst3");
      reset1 = 1'b0; reset3 = 1'b0; mem_clr = 1'b0;
      @(posedge clk); #1;

      // Store / load word, byte loads with both extensions
      run_req("stw4",   0, 0, 1, 1, 0, 32'd4,  32'hDEAD_BEEF, 0, 32'd0);
      run_req("ldw4",   0, 1, 0, 1, 0, 32'd4,  32'h0,         0, 32'hDEAD_BEEF);
      run_req("ldb7s",  0, 1, 0, 0, 1, 32'd7,  32'h0,         0, 32'hFFFF_FFDE);
      run_req("ldb7u",  0, 1, 0, 0, 0, 32'd7,  32'h0,         0, 32'h0000_00DE);
      run_req("ldb5u",  0, 1, 0, 0, 0, 32'd5,  32'h0,         0, 32'h0000_00BE);
      run_req("stb21",  0, 0, 1, 0, 0, 32'd21, 32'h1234_5681, 0, 32'd0);
      run_req("ldb21s", 0, 1, 0, 0, 1, 32'd21, 32'h0,         0, 32'hFFFF_FF81);
      run_req("ldw18",  0, 1, 0, 1, 0, 32'd18, 32'h0,         0, 32'h8100_0000);

      // Illegal requests
      run_req("ldw19",  0, 1, 0, 1, 0, 32'd19, 32'h0,         1, 32'd0);
      run_req("stb22",  0, 0, 1, 0, 0, 32'd22, 32'h55,        1, 32'd0);
      run_req("ldst",   0, 1, 1, 1, 0, 32'd0,  32'h0,         1, 32'd0);
      run_req("none",   0, 0, 0, 0, 0, 32'd0,  32'h0,         1, 32'd0);
      run_req("ldwbig", 0, 1, 0, 1, 0, 32'hFFFF_FFFE, 32'h0,  1, 32'd0);

      // Unaligned word load
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      run_req("ldw5",   0, 1, 0, 1, 0, 32'd5,  32'h0,         1, 32'd0);
`else
      run_req("ldw5",   0, 1, 0, 1, 0, 32'd5,  32'h0,         0, 32'h00DE_ADBE);
`endif

      // Reset in the second access cycle of the latency-3 instance
      sel = 1'b1;
      t_load = 1'b1; t_store = 1'b0; t_word = 1'b1; t_signed = 1'b0;
      t_addr = 32'd0; t_wdata = 32'h0;
      valid3 = 1'b1;
      @(posedge clk); #1;
      valid3 = 1'b0;
      check("mid_rd_c0", 32'(o_rd), 32'd1);
      @(posedge clk); #1;
      check("mid_rd_c1", 32'(o_rd), 32'd1);
      reset3 = 1'b1;
      @(posedge clk); #1;
      reset3 = 1'b0;
      check_reset("mid_rst");
      quiet = 1'b1;
      repeat (5) begin
         if (o_rvalid) quiet = 1'b0;
         @(posedge clk); #1;
      end
      check("mid_no_resp", 32'(quiet), 32'd1);

      run_req("l3_stw8", 1, 0, 1, 1, 0, 32'd8, 32'hCAFE_F00D, 0, 32'd0);
      run_req("l3_ldw8", 1, 1, 0, 1, 0, 32'd8, 32'h0,         0, 32'hCAFE_F00D);
      run_req("l3_ldb9", 1, 1, 0, 0, 1, 32'd9, 32'h0,         0, 32'hFFFF_FFF0);
      run_req("l3_flt",  1, 0, 1, 1, 0, 32'd20, 32'h0,        1, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mem_access_unit
